// File: rtl/flags_unit_if.sv
// Flag-unit connection bundle between the ALU/sequencer side (master) and flags_unit (slave).
// Also provides the default flag-bit positions FLAGS_Z/N/C/V used by the unit and its users.
`ifndef FLAGS_Z
`define FLAGS_Z 0
`endif
`ifndef FLAGS_N
`define FLAGS_N 1
`endif
`ifndef FLAGS_C
`define FLAGS_C 2
`endif
`ifndef FLAGS_V
`define FLAGS_V 3
`endif

interface flags_unit_if;
    logic [3:0] flags_in;
    logic       flags_we;
    logic [3:0] cond_code;
    logic       save;
    logic       restore;
    logic       err_clr;
    logic [3:0] flags;
    logic       carry_out;
    logic       cond_true;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    modport master (
        output flags_in, flags_we, cond_code, save, restore, err_clr,
        input  flags, carry_out, cond_true, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  flags_in, flags_we, cond_code, save, restore, err_clr,
        output flags, carry_out, cond_true, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/flags_unit.sv
// ALU status-flag register, branch-condition evaluator and saved-flag LIFO for interrupts.
// Optional FLAGS_BYPASS_EN forwards flags_in to cond_true/carry_out in the write cycle.
`ifndef FLAGS_Z
`define FLAGS_Z 0
`endif
`ifndef FLAGS_N
`define FLAGS_N 1
`endif
`ifndef FLAGS_C
`define FLAGS_C 2
`endif
`ifndef FLAGS_V
`define FLAGS_V 3
`endif

module flags_unit #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    flags_unit_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    flags_q;
    logic [3:0]    stack [DEPTH];
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;
    logic          err_set;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic [3:0]    eval_flags;
    logic          z, n, c, v;
    logic          cond;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = bus.save & ~bus.restore & ~full;
    assign pop_ok  = bus.restore & ~bus.save & ~empty;
    assign err_set = (bus.save & bus.restore)
                   | (bus.save & ~bus.restore & full)
                   | (bus.restore & ~bus.save & empty);
    assign wr_idx  = IW'(count);
    assign top_idx = IW'(count - 1'b1);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q   <= '0;
            count     <= '0;
            bus.stack_err <= 1'b0;
        end else begin
            if (pop_ok)
                flags_q <= stack[top_idx];
            else if (bus.flags_we)
                flags_q <= bus.flags_in;

            if (push_ok)
                count <= count + 1'b1;
            else if (pop_ok)
                count <= count - 1'b1;

            if (err_set)
                bus.stack_err <= 1'b1;
            else if (bus.err_clr)
                bus.stack_err <= 1'b0;
        end
    end

    // NOTE: the LIFO storage is deliberately not reset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (push_ok)
            stack[wr_idx] <= flags_q;
    end

`ifdef FLAGS_BYPASS_EN
    assign eval_flags = (bus.flags_we & ~bus.restore) ? bus.flags_in : flags_q;
`else
    assign eval_flags = flags_q;
`endif

    assign z = eval_flags[`FLAGS_Z];
    assign n = eval_flags[`FLAGS_N];
    assign c = eval_flags[`FLAGS_C];
    assign v = eval_flags[`FLAGS_V];

    // NOTE: a default ahead of the case keeps this block latch-free and X-free for any code.
    always_comb begin
        cond = 1'b0;
        case (bus.cond_code)
            4'd0:  cond = z;
            4'd1:  cond = ~z;
            4'd2:  cond = c;
            4'd3:  cond = ~c;
            4'd4:  cond = n;
            4'd5:  cond = ~n;
            4'd6:  cond = v;
            4'd7:  cond = ~v;
            4'd8:  cond = c & ~z;
            4'd9:  cond = ~c | z;
            4'd10: cond = (n == v);
            4'd11: cond = (n != v);
            4'd12: cond = ~z & (n == v);
            4'd13: cond = z | (n != v);
            4'd14: cond = 1'b1;
            4'd15: cond = 1'b0;
            default: cond = 1'b0;
        endcase
    end

    assign bus.flags       = flags_q;
    assign bus.carry_out   = eval_flags[`FLAGS_C];
    assign bus.cond_true   = cond;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit (DEPTH=4), covering flags, conditions and the LIFO.
`ifndef FLAGS_Z
`define FLAGS_Z 0
`endif
`ifndef FLAGS_N
`define FLAGS_N 1
`endif
`ifndef FLAGS_C
`define FLAGS_C 2
`endif
`ifndef FLAGS_V
`define FLAGS_V 3
`endif

module tb_flags_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    flags_unit_if bus ();

    flags_unit #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Conditions come in true/inverted pairs; even code gives the base test.
    function automatic logic expect_cond(input logic [3:0] f, input logic [3:0] code);
        logic z, n, c, v, base;
        z = f[`FLAGS_Z];
        n = f[`FLAGS_N];
        c = f[`FLAGS_C];
        v = f[`FLAGS_V];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return code[0] ? !base : base;
    endfunction

    task automatic load(input logic [3:0] val);
        bus.flags_in = val;
        bus.flags_we = 1'b1;
        step();
        bus.flags_we = 1'b0;
    endtask

    initial begin
        logic [3:0] z_only;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.flags_in  = '0;
        bus.flags_we  = 1'b0;
        bus.cond_code = '0;
        bus.save      = 1'b0;
        bus.restore   = 1'b0;
        bus.err_clr   = 1'b0;
        #3;
        check("rst_flags", bus.flags, 4'h0);
        check("rst_carry", {3'b0, bus.carry_out}, 4'h0);
        check("rst_empty", {3'b0, bus.stack_empty}, 4'h1);
        check("rst_full",  {3'b0, bus.stack_full}, 4'h0);
        check("rst_err",   {3'b0, bus.stack_err}, 4'h0);
        step();
        rst = 1'b0;

        // First write: register latency and carry feedback.
        bus.flags_in = 4'hF;
        bus.flags_we = 1'b1;
        #1;
        check("pre_edge_flags", bus.flags, 4'h0);
        step();
        bus.flags_we = 1'b0;
        #1;
        check("post_edge_flags", bus.flags, 4'hF);
        check("post_edge_carry", {3'b0, bus.carry_out}, 4'h1);
        bus.cond_code = 4'd15;
        #1;
        check("cond_nv", {3'b0, bus.cond_true}, 4'h0);
        bus.cond_code = 4'd14;
        #1;
        check("cond_al", {3'b0, bus.cond_true}, 4'h1);

        // Full condition sweep over every flag combination.
        for (int f = 0; f < 16; f++) begin
            load(4'(f));
            for (int cc = 0; cc < 16; cc++) begin
                bus.cond_code = 4'(cc);
                #1;
                check($sformatf("cond_f%0h_c%0d", f, cc), {3'b0, bus.cond_true},
                      {3'b0, expect_cond(4'(f), 4'(cc))});
            end
        end

        // Fill the LIFO with 1..4.
        for (int k = 1; k <= 4; k++) begin
            load(4'(k));
            bus.save = 1'b1;
            step();
            bus.save = 1'b0;
        end
        check("fill_full", {3'b0, bus.stack_full}, 4'h1);
        check("fill_err",  {3'b0, bus.stack_err}, 4'h0);
        bus.save = 1'b1;
        step();
        bus.save = 1'b0;
        check("overflow_err",  {3'b0, bus.stack_err}, 4'h1);
        check("overflow_full", {3'b0, bus.stack_full}, 4'h1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("errclr", {3'b0, bus.stack_err}, 4'h0);

        for (int k = 4; k >= 1; k--) begin
            bus.restore = 1'b1;
            step();
            bus.restore = 1'b0;
            check($sformatf("pop_%0d", k), bus.flags, 4'(k));
        end
        check("drain_empty", {3'b0, bus.stack_empty}, 4'h1);
        check("drain_err",   {3'b0, bus.stack_err}, 4'h0);
        bus.restore = 1'b1;
        step();
        bus.restore = 1'b0;
        check("underflow_err",   {3'b0, bus.stack_err}, 4'h1);
        check("underflow_flags", bus.flags, 4'h1);

        // Save with same-cycle FlagsWe stores the old value.
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        load(4'h5);
        bus.save     = 1'b1;
        bus.flags_we = 1'b1;
        bus.flags_in = 4'hA;
        step();
        bus.save     = 1'b0;
        bus.flags_we = 1'b0;
        check("save_we_flags", bus.flags, 4'hA);
        check("save_we_empty", {3'b0, bus.stack_empty}, 4'h0);
        bus.restore = 1'b1;
        step();
        bus.restore = 1'b0;
        check("save_we_pop", bus.flags, 4'h5);
        check("save_we_empty2", {3'b0, bus.stack_empty}, 4'h1);

        // Save/Restore collision leaves count and Flags alone.
        bus.save = 1'b1;
        step();
        bus.save    = 1'b1;
        bus.restore = 1'b1;
        step();
        bus.save    = 1'b0;
        bus.restore = 1'b0;
        check("collide_err",   {3'b0, bus.stack_err}, 4'h1);
        check("collide_flags", bus.flags, 4'h5);
        check("collide_empty", {3'b0, bus.stack_empty}, 4'h0);
        bus.restore = 1'b1;
        step();
        bus.restore = 1'b0;
        check("collide_count1", {3'b0, bus.stack_empty}, 4'h1);
        bus.save    = 1'b1;
        bus.restore = 1'b1;
        bus.err_clr = 1'b1;
        step();
        bus.save    = 1'b0;
        bus.restore = 1'b0;
        check("set_beats_clr", {3'b0, bus.stack_err}, 4'h1);
        step();
        bus.err_clr = 1'b0;
        check("clr_after", {3'b0, bus.stack_err}, 4'h0);

        // Asynchronous reset with two entries stacked.
        bus.save = 1'b1;
        step();
        step();
        bus.save = 1'b0;
        check("pre_rst_empty", {3'b0, bus.stack_empty}, 4'h0);
        check("pre_rst_flags", bus.flags, 4'h5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_empty", {3'b0, bus.stack_empty}, 4'h1);
        check("async_rst_flags", bus.flags, 4'h0);
        step();
        rst = 1'b0;

        // Same-cycle condition visibility depends on forwarding.
        z_only = '0;
        z_only[`FLAGS_Z] = 1'b1;
        bus.cond_code = 4'd0;
        bus.flags_in  = z_only;
        bus.flags_we  = 1'b1;
        #1;
`ifdef FLAGS_BYPASS_EN
        check("fwd_same_cycle", {3'b0, bus.cond_true}, 4'h1);
`else
        check("fwd_same_cycle", {3'b0, bus.cond_true}, 4'h0);
`endif
        step();
        bus.flags_we = 1'b0;
        #1;
        check("fwd_next_cycle", {3'b0, bus.cond_true}, 4'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/flags_unit.md
Name: flags_unit

Overview:
Status-flag end of the ALU datapath. It registers the 4-bit ALU flag vector and drives the registered carry back as the ALU's CarryIn for ADC/SUC. It evaluates branch conditions from the registered flags. It holds a small LIFO of saved flag words for interrupt entry and return, and sits between the ALU and the control/sequencer.

Parameters:
DEPTH, 4, number of saved-flag entries in the LIFO; legal values 2..16.

Ports:
Clock  input  1  system clock; all state changes on its rising edge.
Reset  input  1  asynchronous, active-high reset.
FlagsIn  input  4  flag vector from the ALU; bit positions follow `FLAGS_Z/`FLAGS_N/`FLAGS_C/`FLAGS_V.
FlagsWe  input  1  capture FlagsIn into the flag register this cycle.
CondCode  input  4  branch condition selector.
Save  input  1  push the current flag register onto the LIFO (interrupt entry).
Restore  input  1  pop the LIFO top into the flag register (return from interrupt).
ErrClr  input  1  clear the sticky StackErr.
Flags  output  4  registered flag vector.
CarryOut  output  1  Flags[`FLAGS_C]; wired to the ALU CarryIn.
CondTrue  output  1  result of CondCode evaluated against Flags.
StackFull  output  1  LIFO holds DEPTH entries.
StackEmpty  output  1  LIFO holds 0 entries.
StackErr  output  1  sticky: overflow, underflow or Save/Restore collision.

Behaviour:
- Reset (async, any time, including mid push/pop):
  - Flags=0, so CarryOut=0.
  - LIFO count=0, so StackEmpty=1 and StackFull=0.
  - StackErr=0.
  - LIFO contents are don't-care.
- Flag register update, one-cycle latency: the value written at edge N is visible on Flags from edge N onward. Priority per edge:
  - Restore valid: Flags <= LIFO top. This overrides FlagsWe.
  - Otherwise FlagsWe: Flags <= FlagsIn.
  - Otherwise: hold.
- LIFO push (Save=1, Restore=0, not full): store the pre-edge Flags value at index count, then count+1. A same-cycle FlagsWe still loads FlagsIn into Flags, so the stack holds the old value.
- LIFO pop (Restore=1, Save=0, not empty): count-1, and Flags <= entry[count-1].
- Save while StackFull: no push, count and contents unchanged, StackErr <= 1. FlagsWe is still honoured.
- Restore while StackEmpty: no pop, Flags is not written by Restore, StackErr <= 1. FlagsWe is still honoured in this case.
- Save and Restore in the same cycle: both ignored, StackErr <= 1. FlagsWe is still honoured.
- ErrClr=1: StackErr <= 0, unless an error condition occurs in the same cycle; setting wins.
- Count never wraps. It saturates at 0 and DEPTH; the error cases above enforce this.
- CondTrue is combinational from Flags. Z, N, C, V below denote the flag bits.
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- No X propagation: every CondCode value decodes to a defined result.

Optional Feature:
FLAGS_BYPASS_EN.
- Defined: when FlagsWe=1 and Restore=0, CondTrue and CarryOut are computed from FlagsIn in the same cycle (forwarding). This lets a compare-and-branch or ADD/ADC pair issue back-to-back. Flags and the register timing are unchanged.
- Undefined: CondTrue and CarryOut always use registered Flags, so a dependent branch or ADC must be one cycle later.

Test Plan:
- Reset then FlagsIn=4'b1111, FlagsWe=1 for one cycle -> Flags=0 before the edge and 4'hF after; CarryOut=1 after the edge; CondCode=15 gives CondTrue=0 and CondCode=14 gives CondTrue=1.
- Load each of the 16 flag combinations and sweep all 16 CondCodes -> CondTrue matches the table for all 256 cases; e.g. N=1, V=0, Z=0 gives LT=1, GE=0, GT=0, LE=1.
- DEPTH=4: load Flags 1,2,3,4 with Save after each load -> StackFull=1. A fifth Save gives StackErr=1 and count stays 4. Four Restores return Flags 4,3,2,1 in that order, then StackEmpty=1. A further Restore gives StackErr=1 and Flags stays 1.
- Same cycle Save=1, FlagsWe=1, FlagsIn=4'hA with Flags=4'h5 -> Flags becomes 4'hA; a later Restore yields Flags=4'h5.
- Save=1 and Restore=1 together -> count unchanged, StackErr=1. Then ErrClr=1 -> StackErr=0. Then assert Reset mid-sequence with count=2 -> StackEmpty=1 and Flags=0 immediately, without waiting for a clock edge.
- With FLAGS_BYPASS_EN: Flags=0, FlagsWe=1, FlagsIn has Z=1, CondCode=0 -> CondTrue=1 in the same cycle. Without the macro -> CondTrue=0 that cycle and 1 in the next.
